// File: rtl/seq_detect_pkg.sv
// Shared defaults, the pattern-length width helper and the character type
// for the parametrised sequence detector.
package seq_detect_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef logic [DEF_DATA_W-1:0] char_t;

    // Width able to hold every length 0..max_len inclusive.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// Character history: MAX_LEN x DATA_W shift register, newest character at
// position 0, with shift enable and synchronous clear.
module seq_hist_shreg
    import seq_detect_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      shift_i,
    input  logic [DATA_W-1:0]         din_i,
    output logic [MAX_LEN*DATA_W-1:0] window_o
);

    logic [MAX_LEN*DATA_W-1:0] hist_q;
    logic [MAX_LEN*DATA_W-1:0] hist_d;

    always_comb begin
        hist_d = hist_q;
        if (clr_i) begin
            hist_d = '0;
        end else if (shift_i) begin
            hist_d = {hist_q[(MAX_LEN-1)*DATA_W-1:0], din_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Window as it stands after this edge, so a shifting beat is already at position 0.
    assign window_o = hist_d;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable sequence detector (1..MAX_LEN characters) on a
// valid-qualified stream, with overlap control and a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      cfg_load,
    input  logic [MAX_LEN*DATA_W-1:0] cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0] cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      count_clr,
    output logic                      seq_dec,
    output logic [CNT_W-1:0]          match_count,
    output logic                      count_sat,
    output logic                      cfg_err
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN*DATA_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      ovl_q, ovl_d;
    logic                      err_q, err_d;
    logic [LEN_W-1:0]          fill_q, fill_d;
    logic                      dec_q, dec_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sat_q, sat_d;

    logic                      beat;
    logic [MAX_LEN*DATA_W-1:0] win;
    logic [MAX_LEN:1]          hit_by_len;
    logic [(1<<LEN_W)-1:0]     len_hit;
    logic [LEN_W:0]            fill_inc;
    logic                      match;

    // A load in the same cycle as a beat discards the beat.
    assign beat = valid & ~cfg_load;

    seq_hist_shreg #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN)
    ) u_hist (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (cfg_load),
        .shift_i  (beat),
        .din_i    (data_in),
        .window_o (win)
    );

    // One comparator bank per candidate length; the shadow length picks one.
    for (genvar l = 1; l <= MAX_LEN; l++) begin : g_len
        logic [MAX_LEN-1:0] eq;
        for (genvar k = 0; k < MAX_LEN; k++) begin : g_chr
            if (k < l) begin : g_cmp
                assign eq[k] = (win[(l-1-k)*DATA_W +: DATA_W] == pat_q[k*DATA_W +: DATA_W]);
            end else begin : g_pad
                assign eq[k] = 1'b1;
            end
        end
        assign hit_by_len[l] = &eq;
    end

    always_comb begin
        len_hit = '0;
        len_hit[MAX_LEN:1] = hit_by_len;
    end

    assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign match    = beat & ~err_q & (fill_inc >= {1'b0, len_q}) & len_hit[len_q];

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        err_d  = err_q;
        fill_d = fill_q;
        dec_d  = match;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            err_d  = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
            fill_d = '0;
        end else if (beat) begin
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
        if (count_clr) begin
            cnt_d = CNT_W'(match);
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (count_clr ? 1'b0 : sat_q) | (cnt_d == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            err_q  <= 1'b0;
            fill_q <= '0;
            dec_q  <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            err_q  <= err_d;
            fill_q <= fill_d;
            dec_q  <= dec_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign seq_dec     = dec_q;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a queue-based reference model checked
// every cycle, plus hand-computed pulse and count expectations per scenario.
module tb_seq_detect_param;
    import seq_detect_pkg::*;

    localparam int unsigned MAXL = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid;
    char_t           data_in;
    logic            cfg_load;
    logic [MAXL*8-1:0] cfg_pattern;
    logic [3:0]      cfg_len;
    logic            cfg_overlap;
    logic            count_clr;
    logic            seq_dec, count_sat, cfg_err;
    logic [15:0]     match_count;
    logic            seq_dec2, count_sat2, cfg_err2;
    logic [1:0]      match_count2;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .seq_dec(seq_dec), .match_count(match_count),
        .count_sat(count_sat), .cfg_err(cfg_err)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .seq_dec(seq_dec2), .match_count(match_count2),
        .count_sat(count_sat2), .cfg_err(cfg_err2)
    );

    // Reference model: configured pattern plus the beats accepted since the
    // last load or non-overlapping match (only the newest MAXL are kept).
    char_t m_pat[MAXL];
    int    m_len = 0;
    bit    m_ovl = 0, m_cfg = 0, m_err = 0;
    char_t m_q[$];
    bit    e_dec = 0;
    int    e_cnt = 0, e_cnt2 = 0;
    bit    e_sat = 0, e_sat2 = 0;

    int tests = 0, fails = 0, pulses = 0;
    bit chk_en = 0;

    function automatic void bump(input bit hit, input int max, inout int cnt, inout bit sat);
        if (count_clr) begin
            cnt = hit ? 1 : 0;
            sat = (cnt == max);
        end else if (hit && cnt < max) begin
            cnt++;
            if (cnt == max) sat = 1;
        end
    endfunction

    task automatic model_step();
        bit hit;
        hit = 0;
        if (cfg_load) begin
            for (int k = 0; k < MAXL; k++) m_pat[k] = cfg_pattern[k*8 +: 8];
            m_len = int'(cfg_len);
            m_ovl = cfg_overlap;
            m_err = (m_len == 0) || (m_len > MAXL);
            m_cfg = 1;
            m_q.delete();
        end else if (valid) begin
            m_q.push_back(data_in);
            if (m_q.size() > MAXL) void'(m_q.pop_front());
            if (m_cfg && !m_err && m_q.size() >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[m_q.size() - m_len + k] != m_pat[k]) hit = 0;
            end
            if (hit && !m_ovl) m_q.delete();
        end
        e_dec = hit;
        bump(hit, 65535, e_cnt, e_sat);
        bump(hit, 3, e_cnt2, e_sat2);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cfg = 0; m_err = 0; m_len = 0; m_ovl = 0; m_q.delete();
            e_dec = 0; e_cnt = 0; e_cnt2 = 0; e_sat = 0; e_sat2 = 0;
        end else begin
            model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("seq_dec",      int'(seq_dec),      int'(e_dec));
            check("match_count",  int'(match_count),  e_cnt);
            check("count_sat",    int'(count_sat),    int'(e_sat));
            check("cfg_err",      int'(cfg_err),      int'(m_err));
            check("seq_dec2",     int'(seq_dec2),     int'(e_dec));
            check("match_count2", int'(match_count2), e_cnt2);
            check("count_sat2",   int'(count_sat2),   int'(e_sat2));
            pulses += int'(seq_dec);
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic beat(input byte ch, input int gap, input bit clr);
        valid = 1'b1; data_in = ch; count_clr = clr;
        @(negedge clk);
        valid = 1'b0; count_clr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic feed(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) beat(s[i], gap, 1'b0);
    endtask

    task automatic load(input string p, input int len, input bit ovl,
                        input bit with_beat = 1'b0, input byte ch = 8'h00);
        cfg_pattern = '0;
        for (int k = 0; k < p.len(); k++) cfg_pattern[k*8 +: 8] = p[k];
        cfg_len = 4'(len); cfg_overlap = ovl; cfg_load = 1'b1;
        valid = with_beat; data_in = ch;
        @(negedge clk);
        cfg_load = 1'b0; valid = 1'b0;
        // Scramble the config inputs: they must only matter on a load.
        cfg_pattern = {$urandom, $urandom}; cfg_len = 4'd1; cfg_overlap = ~ovl;
    endtask

    task automatic clr();
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_run(input string name, input int n, input int cnt);
        repeat (3) @(negedge clk);
        #1;
        check({name, "_pulses"}, pulses, n);
        check({name, "_count"}, int'(match_count), cnt);
        pulses = 0;
        @(negedge clk);
    endtask

    task automatic check_err(input string name, input int exp);
        #1;
        check(name, int'(cfg_err), exp);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; data_in = '0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_dec",   int'(seq_dec),     0);
        check("rst_count", int'(match_count), 0);
        check("rst_sat",   int'(count_sat),   0);
        check("rst_err",   int'(cfg_err),     0);
        @(negedge clk);

        feed("BCCB", 0);                   expect_run("idle", 0, 0);

        load("BCCB", 4, 1'b0); feed("BCCBCCB", 1); expect_run("bccb_ov0", 1, 1);
        clr(); load("BCCB", 4, 1'b1); feed("BCCBCCB", 1); expect_run("bccb_ov1", 2, 2);
        clr(); load("AAA", 3, 1'b1); feed("AAAAA", 0); expect_run("aaa_ov1", 3, 3);
        clr(); load("AAA", 3, 1'b0); feed("AAAAA", 0); expect_run("aaa_ov0", 1, 1);

        clr(); load("BCCB", 4, 1'b0);
        feed("BCCB", 0); expect_run("gap0", 1, 1);
        feed("BCCB", 3); expect_run("gap3", 1, 2);
        feed("BCCB", 7); expect_run("gap7", 1, 3);

        feed("BC", 0); do_reset(); feed("CB", 0); feed("BCCB", 0);
        expect_run("rst_mid", 0, 0);

        load("BCCB", 4, 1'b0); feed("BCC", 0);
        load("BCCB", 4, 1'b0, 1'b1, "B"); feed("CCB", 0);
        expect_run("load_beat", 0, 0);

        load("BBBB", 0, 1'b1); check_err("len0_err", 1);
        feed("BBBB", 0); expect_run("len0", 0, 0);
        load("BBBBBBBB", 9, 1'b1); check_err("len9_err", 1);
        feed("BBBBBBBBB", 0); expect_run("len9", 0, 0);
        load("B", 1, 1'b0); check_err("len1_err", 0);
        feed("BAB", 0); expect_run("len1_ov0", 2, 2);

        clr(); load("A", 1, 1'b1); feed("AAAA", 0); expect_run("sat", 4, 4);
        check("sat2_count", int'(match_count2), 3);
        check("sat2_flag",  int'(count_sat2),   1);
        check("sat16_flag", int'(count_sat),    0);

        beat("A", 0, 1'b1); expect_run("clr_match", 1, 1);
        check("clr_match2", int'(match_count2), 1);
        check("clr_sat2",   int'(count_sat2),   0);
        check("model_cnt",  e_cnt,              1);

        clr(); #1;
        check("clr_only", int'(match_count), 0);
        @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
